// File: rtl/stream_min_max_if.sv
// Handshake bundle for stream_min_max: beat stream in, min/max result out.
interface stream_min_max_if #(
   parameter int N    = 8,
   parameter int IDXW = 8
);
   logic            in_valid;
   logic            in_ready;
   logic [N-1:0]    in_data;
   logic            in_last;
   logic            out_valid;
   logic            out_ready;
   logic [N-1:0]    out_min;
   logic [N-1:0]    out_max;
   logic [IDXW-1:0] out_min_idx;
   logic [IDXW-1:0] out_max_idx;
   logic [IDXW-1:0] out_count;
   logic            out_ovf;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_min, out_max,
      input  out_min_idx, out_max_idx, out_count, out_ovf
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_min, out_max,
      output out_min_idx, out_max_idx, out_count, out_ovf
   );
endinterface

// File: rtl/stream_min_max.sv
// Per-packet min/max/index/count tracker over a valid/ready beat stream.
// Define STREAM_MIN_MAX_SIGNED_EN for two's-complement compares.
module stream_min_max #(
   parameter int N    = 8,
   parameter int IDXW = 8
) (
   input logic             clk,
   input logic             rst,
   stream_min_max_if.slave bus_io
);
   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      HOLD
   } state_e;

   localparam logic [IDXW-1:0] CMAX = '1;
   localparam logic [IDXW-1:0] ONE  = IDXW'(1);

   // Flipping the sign bit maps signed order onto unsigned order.
`ifdef STREAM_MIN_MAX_SIGNED_EN
   localparam logic [N-1:0] FLIP = {1'b1, {(N-1){1'b0}}};
`else
   localparam logic [N-1:0] FLIP = '0;
`endif

   state_e          state_q, state_d;
   logic            rdy_q;
   logic [N-1:0]    min_q, min_d;
   logic [N-1:0]    max_q, max_d;
   logic [IDXW-1:0] min_idx_q, min_idx_d;
   logic [IDXW-1:0] max_idx_q, max_idx_d;
   logic [IDXW-1:0] cnt_q, cnt_d;
   logic            ovf_q, ovf_d;

   logic            in_ready;
   logic            out_valid;
   logic            acc;
   logic            lt_min;
   logic            gt_max;
   logic            sat;
   logic [N-1:0]    key_in;
   logic [N-1:0]    key_min;
   logic [N-1:0]    key_max;

   function automatic logic nib_lt(
      input logic [N-1:0] a,
      input logic [N-1:0] b
   );
      logic done;
      logic res;
      done = 1'b0;
      res  = 1'b0;
      for (int k = N/4 - 1; k >= 0; k--) begin
         if (!done && (a[4*k +: 4] != b[4*k +: 4])) begin
            res  = a[4*k +: 4] < b[4*k +: 4];
            done = 1'b1;
         end
      end
      return res;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (acc) begin
               state_d = bus_io.in_last ? HOLD : ACCUM;
            end
         end
         ACCUM: begin
            if (acc && bus_io.in_last) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (bus_io.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE, ACCUM: in_ready = rdy_q;
         HOLD:        out_valid = 1'b1;
         default:     in_ready = 1'b0;
      endcase
   end

   assign acc     = bus_io.in_valid & in_ready;
   assign key_in  = bus_io.in_data ^ FLIP;
   assign key_min = min_q ^ FLIP;
   assign key_max = max_q ^ FLIP;
   assign lt_min  = nib_lt(key_in, key_min);
   assign gt_max  = nib_lt(key_max, key_in);
   assign sat     = (cnt_q == CMAX);

   // Index of a beat is the pre-increment count, so it clamps with it.
   always_comb begin
      min_d     = min_q;
      max_d     = max_q;
      min_idx_d = min_idx_q;
      max_idx_d = max_idx_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      if (acc) begin
         if (state_q == IDLE) begin
            min_d     = bus_io.in_data;
            max_d     = bus_io.in_data;
            min_idx_d = '0;
            max_idx_d = '0;
            cnt_d     = ONE;
            ovf_d     = 1'b0;
         end else begin
            if (lt_min) begin
               min_d     = bus_io.in_data;
               min_idx_d = cnt_q;
            end
            if (gt_max) begin
               max_d     = bus_io.in_data;
               max_idx_d = cnt_q;
            end
            if (sat) begin
               ovf_d = 1'b1;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy_q     <= 1'b0;
         min_q     <= '0;
         max_q     <= '0;
         min_idx_q <= '0;
         max_idx_q <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
      end else begin
         rdy_q     <= 1'b1;
         min_q     <= min_d;
         max_q     <= max_d;
         min_idx_q <= min_idx_d;
         max_idx_q <= max_idx_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
      end
   end

   assign bus_io.in_ready    = in_ready;
   assign bus_io.out_valid   = out_valid;
   assign bus_io.out_min     = min_q;
   assign bus_io.out_max     = max_q;
   assign bus_io.out_min_idx = min_idx_q;
   assign bus_io.out_max_idx = max_idx_q;
   assign bus_io.out_count   = cnt_q;
   assign bus_io.out_ovf     = ovf_q;
endmodule

// File: tb/tb_stream_min_max.sv
// Bench for stream_min_max: directed vectors, corner sequences, random packets.
module tb_stream_min_max;
   typedef struct {
      logic [7:0] mn;
      logic [7:0] mx;
      int         mni;
      int         mxi;
      int         cnt;
      bit         ovf;
   } res_t;

   typedef struct {
      int         len;
      logic [7:0] d [4];
      res_t       r;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_run  = 0;
   int   n_fail = 0;
   vec_t tv [6];

   always #5 clk = ~clk;

   stream_min_max_if #(.N(8), .IDXW(8)) bif ();
   stream_min_max_if #(.N(8), .IDXW(2)) sif ();

   stream_min_max #(.N(8), .IDXW(8)) u_big (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bif)
   );

   stream_min_max #(.N(8), .IDXW(2)) u_small (
      .clk    (clk),
      .rst    (rst),
      .bus_io (sif)
   );

   function automatic res_t mkres(input logic [7:0] mn, input logic [7:0] mx,
                                  input int mni, input int mxi,
                                  input int cnt, input bit ovf);
      res_t r;
      r.mn  = mn;
      r.mx  = mx;
      r.mni = mni;
      r.mxi = mxi;
      r.cnt = cnt;
      r.ovf = ovf;
      return r;
   endfunction

   function automatic vec_t mkv(input int len,
                                input logic [7:0] d0, input logic [7:0] d1,
                                input logic [7:0] d2, input logic [7:0] d3,
                                input res_t r);
      vec_t v;
      v.len  = len;
      v.d[0] = d0;
      v.d[1] = d1;
      v.d[2] = d2;
      v.d[3] = d3;
      v.r    = r;
      return v;
   endfunction

   function automatic bit lt_ref(input logic [7:0] a, input logic [7:0] b);
`ifdef STREAM_MIN_MAX_SIGNED_EN
      return $signed(a) < $signed(b);
`else
      return a < b;
`endif
   endfunction

   // Reference: first occurrence of the extreme value, index clamped to maxc.
   function automatic res_t model(input logic [7:0] q[$], input int maxc);
      res_t r;
      int   mi;
      int   xi;
      mi = 0;
      xi = 0;
      foreach (q[i]) begin
         if (lt_ref(q[i], q[mi])) mi = i;
         if (lt_ref(q[xi], q[i])) xi = i;
      end
      r.mn  = q[mi];
      r.mx  = q[xi];
      r.mni = (mi > maxc) ? maxc : mi;
      r.mxi = (xi > maxc) ? maxc : xi;
      r.cnt = (q.size() > maxc) ? maxc : q.size();
      r.ovf = q.size() > maxc;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_res(input string nm, input res_t a, input res_t e);
      chk({nm, " min"},     32'(a.mn),  32'(e.mn));
      chk({nm, " max"},     32'(a.mx),  32'(e.mx));
      chk({nm, " min_idx"}, 32'(a.mni), 32'(e.mni));
      chk({nm, " max_idx"}, 32'(a.mxi), 32'(e.mxi));
      chk({nm, " count"},   32'(a.cnt), 32'(e.cnt));
      chk({nm, " ovf"},     32'(a.ovf), 32'(e.ovf));
   endtask

   task automatic drive(input int sel, input logic v, input logic [7:0] d,
                        input logic l);
      if (sel == 0) begin
         bif.in_valid = v;
         bif.in_data  = d;
         bif.in_last  = l;
      end else begin
         sif.in_valid = v;
         sif.in_data  = d;
         sif.in_last  = l;
      end
   endtask

   task automatic set_ordy(input int sel, input logic r);
      if (sel == 0) bif.out_ready = r;
      else          sif.out_ready = r;
   endtask

   function automatic logic rdy(input int sel);
      return (sel == 0) ? bif.in_ready : sif.in_ready;
   endfunction

   function automatic logic ovld(input int sel);
      return (sel == 0) ? bif.out_valid : sif.out_valid;
   endfunction

   function automatic res_t rd(input int sel);
      res_t r;
      if (sel == 0) begin
         r = mkres(bif.out_min, bif.out_max, int'(bif.out_min_idx),
                   int'(bif.out_max_idx), int'(bif.out_count), bif.out_ovf);
      end else begin
         r = mkres(sif.out_min, sif.out_max, int'(sif.out_min_idx),
                   int'(sif.out_max_idx), int'(sif.out_count), sif.out_ovf);
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_pkt(input int sel, input logic [7:0] q[$], input res_t e,
                          input bit gaps, input bit stall, input string nm);
      int   i;
      int   guard;
      logic go;
      int   dly;
      res_t hold;
      i = 0;
      guard = 0;
      while (i < q.size() && guard < 200) begin
         guard++;
         go = !(gaps && $urandom_range(0, 3) == 0);
         drive(sel, go, go ? q[i] : 8'h00, go && (i == q.size() - 1));
         go = go && rdy(sel);
         tick();
         if (go) i++;
      end
      drive(sel, 1'b0, 8'h00, 1'b0);
      chk({nm, " beats"}, 32'(i), 32'(q.size()));
      chk({nm, " valid"}, 32'(ovld(sel)), 32'd1);
      hold = rd(sel);
      chk_res(nm, hold, e);
      if (stall) begin
         for (int c = 0; c < 5; c++) begin
            drive(sel, 1'b1, 8'h00, 1'b1);
            tick();
            chk({nm, " stall rdy"}, 32'(rdy(sel)), 32'd0);
            chk({nm, " stall vld"}, 32'(ovld(sel)), 32'd1);
            chk_res({nm, " stall"}, rd(sel), hold);
         end
         drive(sel, 1'b0, 8'h00, 1'b0);
      end else begin
         dly = $urandom_range(0, 2);
         repeat (dly) tick();
         chk({nm, " held vld"}, 32'(ovld(sel)), 32'd1);
      end
      set_ordy(sel, 1'b1);
      tick();
      set_ordy(sel, 1'b0);
      chk({nm, " drained"}, 32'(ovld(sel)), 32'd0);
      chk({nm, " rdy again"}, 32'(rdy(sel)), 32'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] q[$];
      int         len;

      rst = 1'b1;
      drive(0, 1'b0, 8'h00, 1'b0);
      drive(1, 1'b0, 8'h00, 1'b0);
      set_ordy(0, 1'b0);
      set_ordy(1, 1'b0);

      tv[0] = mkv(1, 8'h5A, 8'h00, 8'h00, 8'h00,
                  mkres(8'h5A, 8'h5A, 0, 0, 1, 0));
      tv[1] = mkv(4, 8'h10, 8'h03, 8'hF0, 8'h03,
                  mkres(8'h03, 8'hF0, 1, 2, 4, 0));
`ifdef STREAM_MIN_MAX_SIGNED_EN
      tv[2] = mkv(2, 8'h7F, 8'h80, 8'h00, 8'h00,
                  mkres(8'h80, 8'h7F, 1, 0, 2, 0));
      tv[4] = mkv(3, 8'hFF, 8'h00, 8'hFF, 8'h00,
                  mkres(8'hFF, 8'h00, 0, 1, 3, 0));
`else
      tv[2] = mkv(2, 8'h7F, 8'h80, 8'h00, 8'h00,
                  mkres(8'h7F, 8'h80, 0, 1, 2, 0));
      tv[4] = mkv(3, 8'hFF, 8'h00, 8'hFF, 8'h00,
                  mkres(8'h00, 8'hFF, 1, 0, 3, 0));
`endif
      tv[3] = mkv(3, 8'h09, 8'h09, 8'h09, 8'h00,
                  mkres(8'h09, 8'h09, 0, 0, 3, 0));
      tv[5] = mkv(4, 8'h12, 8'h34, 8'h21, 8'h43,
                  mkres(8'h12, 8'h43, 0, 3, 4, 0));

      repeat (2) @(negedge clk);
      chk("rst rdy", 32'(rdy(0)), 32'd0);
      chk("rst vld", 32'(ovld(0)), 32'd0);
      chk_res("rst", rd(0), mkres(8'h00, 8'h00, 0, 0, 0, 0));
      rst = 1'b0;
      chk("rdy before first edge", 32'(rdy(0)), 32'd0);
      tick();
      chk("rdy after first edge", 32'(rdy(0)), 32'd1);

      for (int k = 0; k < 6; k++) begin
         q.delete();
         for (int j = 0; j < tv[k].len; j++) q.push_back(tv[k].d[j]);
         run_pkt(0, q, tv[k].r, 1'b0, k == 1, $sformatf("vec%0d", k));
      end

      q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0};
      run_pkt(1, q, mkres(8'd0, 8'd4, 3, 3, 3, 1), 1'b0, 1'b0, "idxw2");

      for (int p = 0; p < 40; p++) begin
         len = $urandom_range(1, 12);
         q.delete();
         for (int j = 0; j < len; j++) q.push_back(8'($urandom));
         run_pkt(0, q, model(q, 255), 1'b1, 1'b0, $sformatf("rnd%0d", p));
      end

      for (int p = 0; p < 15; p++) begin
         len = $urandom_range(1, 7);
         q.delete();
         for (int j = 0; j < len; j++) q.push_back(8'($urandom));
         run_pkt(1, q, model(q, 3), 1'b1, 1'b0, $sformatf("srnd%0d", p));
      end

      drive(0, 1'b1, 8'h40, 1'b0);
      tick();
      drive(0, 1'b1, 8'h50, 1'b0);
      tick();
      drive(0, 1'b0, 8'h00, 1'b0);
      chk("partial count", 32'(bif.out_count), 32'd2);
      #2 rst = 1'b1;
      #1;
      chk("async rst rdy", 32'(rdy(0)), 32'd0);
      chk("async rst vld", 32'(ovld(0)), 32'd0);
      chk_res("async rst", rd(0), mkres(8'h00, 8'h00, 0, 0, 0, 0));
      @(negedge clk);
      rst = 1'b0;
      tick();
      q = '{8'h22};
      run_pkt(0, q, mkres(8'h22, 8'h22, 0, 0, 1, 0), 1'b0, 1'b0, "post rst");

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule

// File: doc/stream_min_max.md
STREAM_MIN_MAX -- requirements
Module: stream_min_max

Interface
REQ-001 Parameter N, default 8: operand width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 Parameter IDXW, default 8: beat index and count width in bits.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-high.
REQ-005 in_valid  input  1  input beat valid.
REQ-006 in_ready  output  1  block accepts a beat; a transfer occurs when in_valid & in_ready at the clock edge.
REQ-007 in_data  input  N  operand of the current beat.
REQ-008 in_last  input  1  marks the final beat of a packet.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_min  output  N  smallest operand in the packet.
REQ-012 out_max  output  N  largest operand in the packet.
REQ-013 out_min_idx  output  IDXW  beat index (0-based) of out_min.
REQ-014 out_max_idx  output  IDXW  beat index of out_max.
REQ-015 out_count  output  IDXW  number of beats accepted, saturating.
REQ-016 out_ovf  output  1  packet length exceeded 2^IDXW-1 beats.

Function
REQ-017 The FSM SHALL have states IDLE, ACCUM and HOLD; in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD.
REQ-018 In IDLE, an accepted beat SHALL load min=max=in_data, min_idx=max_idx=0, count=1, and go to ACCUM; if in_last is also set, go directly to HOLD.
REQ-019 In ACCUM, each accepted beat SHALL replace min only when in_data < min (strict), and max only when in_data > max (strict); ties keep the earliest index.
REQ-020 Comparisons SHALL be unsigned by default and are computed 4 bits at a time, MSB nibble first, within a single cycle.
REQ-021 The beat index SHALL equal count before increment; count SHALL saturate at 2^IDXW-1, and out_ovf SHALL set when a beat arrives at saturation; the indices of later beats SHALL be clamped to 2^IDXW-1.
REQ-022 A beat accepted with in_last SHALL move the FSM to HOLD; out_valid SHALL be 1 on the next cycle, with results including that beat (latency 1 cycle).
REQ-023 In HOLD, all out_* SHALL stay stable until out_valid & out_ready, then go to IDLE; in_ready SHALL be 1 in the following cycle, with no bypass.
REQ-024 in_valid while in HOLD SHALL be ignored, with no state change.
REQ-025 out_* values other than out_valid SHALL be don't-care when out_valid=0, but the implementation SHALL hold the last computed values.

Reset
REQ-026 While rst=1: FSM=IDLE, in_ready=0, out_valid=0, out_min=0, out_max=0, both indices=0, out_count=0, out_ovf=0.
REQ-027 in_ready SHALL return to 1 on the first clock edge after rst deasserts.
REQ-028 Asserting rst mid-packet or in HOLD SHALL discard the partial or pending result immediately, without waiting for a clock edge.

Configuration
REQ-029 When macro STREAM_MIN_MAX_SIGNED_EN is defined, comparisons SHALL treat in_data as two's-complement signed; when it is undefined, comparisons SHALL be unsigned; no other behaviour changes.

Verification
REQ-030 Single-beat packet in_data=8'h5A with in_last -> next cycle out_valid=1, min=max=8'h5A, indices 0, count=1.
REQ-031 Packet 8'h10, 8'h03, 8'hF0, 8'h03 (last) -> min=8'h03, min_idx=1, max=8'hF0, max_idx=2, count=4.
REQ-032 Packet 8'h7F, 8'h80 (last) -> unsigned: min=8'h7F, max=8'h80; with STREAM_MIN_MAX_SIGNED_EN: min=8'h80, max=8'h7F.
REQ-033 Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, outputs stable, no beat consumed; out_ready=1 -> IDLE, in_ready=1 the next cycle.
REQ-034 IDXW=2, 5-beat packet 1,2,3,4,0 (last) -> count=3, out_ovf=1, max=4 with max_idx=3, min=0 with min_idx=3.
REQ-035 Assert rst after 2 beats of a packet -> outputs cleared asynchronously; a new packet 8'h22 (last) reports min=max=8'h22, count=1.
